// File: rtl/dfe_sslms_bdrate_if.sv
// Sample-stream bundle between the FFE/driver side and the baud-rate DFE.
// master: producer of din words and consumer of equalized outputs.
// slave : the DFE itself.
interface dfe_sslms_bdrate_if #(
  parameter int Nti  = 1,
  parameter int Nadc = 8
);
  logic                in_valid;
  logic [Nti*Nadc-1:0] din;
  logic                out_valid;
  logic [Nti*Nadc-1:0] eq_out;
  logic [Nti-1:0]      dout;

  modport master (output in_valid, din, input out_valid, eq_out, dout);
  modport slave  (input in_valid, din, output out_valid, eq_out, dout);
endinterface

// File: rtl/dfe_sslms_bdrate.sv
// Baud-rate Nti-way decision-feedback equalizer with sign-sign LMS tap
// adaptation over block-averaged windows of 2**Nwin valid words.
// Slice 0 is the oldest sample of a word; decisions ripple slice-to-slice.
// Optional feature macro: DFE_EYEMON_EN adds the eye_viol counter port.
module dfe_sslms_bdrate #(
  parameter int Nadc  = 8,
  parameter int Nti   = 1,
  parameter int Ndfe  = 2,
  parameter int Ncoef = 6,
  parameter int Nwin  = 6
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  bypass,
  input  logic [Nadc-2:0]       dlev,
  input  logic                  adapt_en,
  input  logic                  load_coef,
  input  logic [Ndfe*Ncoef-1:0] coef_init,
  output logic [Ndfe*Ncoef-1:0] coef,
  output logic                  adapt_busy,
`ifdef DFE_EYEMON_EN
  output logic [15:0]           eye_viol,
`endif
  dfe_sslms_bdrate_if.slave     dif
);

  localparam int SW = Nadc + Ncoef + $clog2(Ndfe) + 1;
  localparam int AW = Nwin + $clog2(Nti) + 2;
  localparam int HN = Ndfe + Nti;
  localparam int EW = Nadc + 1;

  localparam logic signed [SW-1:0]    EQ_MAX   = SW'(2**(Nadc-1) - 1);
  localparam logic signed [SW-1:0]    EQ_MIN   = ~EQ_MAX;
  localparam logic signed [Ncoef:0]   CF_MAX   = (Ncoef+1)'(2**(Ncoef-1) - 1);
  localparam logic signed [Ncoef:0]   CF_MIN   = ~CF_MAX;
  localparam logic signed [AW-1:0]    ACC_ONE  = AW'(1);
  localparam logic [Nwin-1:0]         CNT_LAST = '1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;

  function automatic logic signed [Nadc-1:0] sat_eq(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] r;
    if (v > EQ_MAX)      r = EQ_MAX;
    else if (v < EQ_MIN) r = EQ_MIN;
    else                 r = v;
    return r[Nadc-1:0];
  endfunction

  function automatic logic signed [Ncoef-1:0] sat_coef(input logic signed [Ncoef:0] v);
    logic signed [Ncoef:0] r;
    if (v > CF_MAX)      r = CF_MAX;
    else if (v < CF_MIN) r = CF_MIN;
    else                 r = v;
    return r[Ncoef-1:0];
  endfunction

  // +1 / -1 / 0 step from the sign of a window accumulator
  function automatic logic signed [Ncoef:0] sign_step(input logic signed [AW-1:0] a);
    if (a[AW-1])      return '1;
    else if (a != '0) return (Ncoef+1)'(1);
    else              return '0;
  endfunction

  logic [1:0]                 state_q, state_d;
  logic [Nwin-1:0]            cnt_q, cnt_d;
  logic signed [AW-1:0]       acc_q [Ndfe];
  logic signed [AW-1:0]       acc_d [Ndfe];
  logic [Ndfe*Ncoef-1:0]      coef_q, coef_d;
  logic [Ndfe-1:0]            hist_q, hist_d;
  logic [Nti*Nadc-1:0]        eq_out_q, eq_out_d;
  logic [Nti-1:0]             dout_q, dout_d;
  logic                       out_valid_q, out_valid_d;

  logic [HN-1:0]              chain;
  logic [Nti*Nadc-1:0]        eq_w;
  logic [Nti-1:0]             dec_w, se_w;
  logic signed [AW-1:0]       acc_add [Ndfe];
  logic signed [Nadc-1:0]     dp_x, dp_e;
  logic signed [SW-1:0]       dp_sum;
  logic signed [Ncoef-1:0]    dp_cf;
  logic signed [EW-1:0]       dp_tgt, dp_err;
  logic                       clr;

  // Feedback subtraction, slicing, error slicing and SS-LMS correlation terms
  always_comb begin
    chain  = '0;
    eq_w   = '0;
    dec_w  = '0;
    se_w   = '0;
    dp_x   = '0;
    dp_e   = '0;
    dp_sum = '0;
    dp_cf  = '0;
    dp_tgt = '0;
    dp_err = '0;
    for (int i = 0; i < Ndfe; i++) chain[Ndfe-1-i] = hist_q[i];
    for (int j = 0; j < Nti; j++) begin
      dp_x   = dif.din[j*Nadc +: Nadc];
      dp_sum = {{(SW-Nadc){dp_x[Nadc-1]}}, dp_x};
      for (int k = 0; k < Ndfe; k++) begin
        dp_cf = coef_q[k*Ncoef +: Ncoef];
        if (chain[Ndfe+j-k-1]) dp_sum = dp_sum - {{(SW-Ncoef){dp_cf[Ncoef-1]}}, dp_cf};
        else                   dp_sum = dp_sum + {{(SW-Ncoef){dp_cf[Ncoef-1]}}, dp_cf};
      end
      dp_e                  = bypass ? dp_x : sat_eq(dp_sum);
      eq_w[j*Nadc +: Nadc]  = dp_e;
      dec_w[j]              = ~dp_e[Nadc-1];
      chain[Ndfe+j]         = dec_w[j];
      dp_tgt                = dec_w[j] ? {2'b00, dlev} : -{2'b00, dlev};
      dp_err                = {dp_e[Nadc-1], dp_e} - dp_tgt;
      se_w[j]               = ~dp_err[EW-1];
    end
    for (int k = 0; k < Ndfe; k++) begin
      acc_add[k] = '0;
      for (int j = 0; j < Nti; j++) begin
        if (se_w[j] == chain[Ndfe+j-k-1]) acc_add[k] = acc_add[k] + ACC_ONE;
        else                              acc_add[k] = acc_add[k] - ACC_ONE;
      end
    end
    for (int i = 0; i < Ndfe; i++) hist_d[i] = dif.in_valid ? chain[HN-1-i] : hist_q[i];
    eq_out_d    = dif.in_valid ? eq_w  : eq_out_q;
    dout_d      = dif.in_valid ? dec_w : dout_q;
    out_valid_d = dif.in_valid;
  end

  // Adaptation FSM, window accumulators and tap update; load_coef wins over all
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    coef_d  = coef_q;
    clr     = 1'b0;
    for (int k = 0; k < Ndfe; k++) acc_d[k] = acc_q[k];
    case (state_q)
      S_IDLE: begin
        if (adapt_en) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (!adapt_en) begin
          state_d = S_IDLE;
          clr     = 1'b1;
        end else if (dif.in_valid) begin
          for (int k = 0; k < Ndfe; k++) acc_d[k] = acc_q[k] + acc_add[k];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        for (int k = 0; k < Ndfe; k++)
          coef_d[k*Ncoef +: Ncoef] = sat_coef({coef_q[k*Ncoef+Ncoef-1], coef_q[k*Ncoef +: Ncoef]}
                                              + sign_step(acc_q[k]));
        clr     = 1'b1;
        state_d = adapt_en ? S_ACCUM : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        clr     = 1'b1;
      end
    endcase
    if (bypass) begin
      state_d = S_IDLE;
      clr     = 1'b1;
      coef_d  = coef_q;
    end
    if (load_coef) begin
      state_d = S_IDLE;
      clr     = 1'b1;
      coef_d  = coef_init;
    end
    if (clr) begin
      cnt_d = '0;
      for (int k = 0; k < Ndfe; k++) acc_d[k] = '0;
    end
  end

  // Output registers and decision history; frozen on cycles without a word
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      eq_out_q    <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      hist_q      <= '0;
    end else begin
      eq_out_q    <= eq_out_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      hist_q      <= hist_d;
    end
  end

  // Adaptation state, window counter, accumulators and taps
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      coef_q  <= '0;
      for (int k = 0; k < Ndfe; k++) acc_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      coef_q  <= coef_d;
      for (int k = 0; k < Ndfe; k++) acc_q[k] <= acc_d[k];
    end
  end

`ifdef DFE_EYEMON_EN
  logic [15:0]          eye_q, eye_d;
  logic signed [EW-1:0] em_ext;
  logic [EW-1:0]        em_mag;

  // Saturating count of valid samples falling inside half the data level
  always_comb begin
    eye_d  = eye_q;
    em_ext = '0;
    em_mag = '0;
    if (load_coef) begin
      eye_d = '0;
    end else if (dif.in_valid) begin
      for (int j = 0; j < Nti; j++) begin
        em_ext = {eq_w[j*Nadc+Nadc-1], eq_w[j*Nadc +: Nadc]};
        em_mag = em_ext[EW-1] ? -em_ext : em_ext;
        if ((em_mag < {3'b000, dlev[Nadc-2:1]}) && (eye_d != 16'hFFFF)) eye_d = eye_d + 16'd1;
      end
    end
  end

  // Eye violation counter register
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) eye_q <= '0;
    else       eye_q <= eye_d;
  end

  assign eye_viol = eye_q;
`endif

  assign coef          = coef_q;
  assign adapt_busy    = (state_q == S_ACCUM) || (state_q == S_UPDATE);
  assign dif.eq_out    = eq_out_q;
  assign dif.dout      = dout_q;
  assign dif.out_valid = out_valid_q;

endmodule

// File: tb/tb_dfe_sslms_bdrate.sv
// Directed + randomized bench for dfe_sslms_bdrate (Nti=1, Ndfe=2) with an
// arithmetic reference model of the equalizer and SS-LMS adaptation.
module tb_dfe_sslms_bdrate;
  localparam int NADC = 8, NTI = 1, NDFE = 2, NCOEF = 6, NWIN = 6;
  localparam int WIN  = 2**NWIN;

  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  logic                   bypass, adapt_en, load_coef, adapt_busy;
  logic [NADC-2:0]        dlev;
  logic [NDFE*NCOEF-1:0]  coef_init, coef;
`ifdef DFE_EYEMON_EN
  logic [15:0]            eye_viol;
`endif

  dfe_sslms_bdrate_if #(.Nti(NTI), .Nadc(NADC)) dif ();

  dfe_sslms_bdrate #(.Nadc(NADC), .Nti(NTI), .Ndfe(NDFE), .Ncoef(NCOEF), .Nwin(NWIN)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .bypass     (bypass),
    .dlev       (dlev),
    .adapt_en   (adapt_en),
    .load_coef  (load_coef),
    .coef_init  (coef_init),
    .coef       (coef),
    .adapt_busy (adapt_busy),
`ifdef DFE_EYEMON_EN
    .eye_viol   (eye_viol),
`endif
    .dif        (dif)
  );

  int vectors = 0, miscompares = 0;

  // reference model state
  int m_coef[2], m_acc[2], m_hist[2];
  int m_cnt, m_eq, m_eye;
  bit m_adapting, m_upd_due, m_dout, m_vld;
  int g_dlev, g_ci0, g_ci1;
  logic [6:0] lfsr;
  int a_prev;

  function automatic int clamp(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic int sgn(int v);
    return (v > 0) ? 1 : (v < 0) ? -1 : 0;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin m_coef[k] = 0; m_acc[k] = 0; m_hist[k] = -1; end
    m_cnt = 0; m_eq = 0; m_eye = 0;
    m_adapting = 0; m_upd_due = 0; m_dout = 0; m_vld = 0;
  endfunction

  function automatic void model_clear();
    m_acc[0] = 0; m_acc[1] = 0; m_cnt = 0;
  endfunction

  function automatic void model_step(int din, bit vld, bit byp, bit aen, bit ld);
    int s, eq, e, se;
    bit dec;
    eq = m_eq; dec = m_dout; se = 1;
    if (vld) begin
      s   = byp ? din : din - m_coef[0]*m_hist[0] - m_coef[1]*m_hist[1];
      eq  = clamp(s, -128, 127);
      dec = (eq >= 0);
      e   = eq - (dec ? g_dlev : -g_dlev);
      se  = (e >= 0) ? 1 : -1;
    end
    if (ld) begin
      m_coef[0] = g_ci0; m_coef[1] = g_ci1;
      model_clear(); m_adapting = 0; m_upd_due = 0;
    end else if (byp) begin
      model_clear(); m_adapting = 0; m_upd_due = 0;
    end else if (m_upd_due) begin
      for (int k = 0; k < 2; k++) m_coef[k] = clamp(m_coef[k] + sgn(m_acc[k]), -32, 31);
      model_clear(); m_upd_due = 0; m_adapting = aen;
    end else if (m_adapting) begin
      if (!aen) begin
        m_adapting = 0; model_clear();
      end else if (vld) begin
        for (int k = 0; k < 2; k++) m_acc[k] += se * m_hist[k];
        m_cnt++;
        if (m_cnt == WIN) begin m_adapting = 0; m_upd_due = 1; end
      end
    end else if (aen) begin
      m_adapting = 1;
    end
    if (vld) begin
      if (((eq < 0) ? -eq : eq) < g_dlev/2 && m_eye < 65535) m_eye++;
      m_hist[1] = m_hist[0];
      m_hist[0] = dec ? 1 : -1;
    end
    if (ld) m_eye = 0;
    m_eq = eq; m_dout = dec; m_vld = vld;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0]  e8;
    logic [11:0] ec;
    e8 = 8'(m_eq);
    ec = {6'(m_coef[1]), 6'(m_coef[0])};
    chk({tag, "_vld"},  32'(dif.out_valid), 32'(m_vld));
    chk({tag, "_eq"},   32'(dif.eq_out),    32'(e8));
    chk({tag, "_dout"}, 32'(dif.dout),      32'(m_dout));
    chk({tag, "_coef"}, 32'(coef),          32'(ec));
    chk({tag, "_busy"}, 32'(adapt_busy),    32'(m_adapting | m_upd_due));
`ifdef DFE_EYEMON_EN
    chk({tag, "_eye"},  32'(eye_viol),      32'(m_eye));
`endif
  endtask

  task automatic step(input string tag, input int din, input bit vld, input bit byp,
                      input bit aen, input bit ld);
    dif.din      = 8'(din);
    dif.in_valid = vld;
    bypass       = byp;
    adapt_en     = aen;
    load_coef    = ld;
    coef_init    = {6'(g_ci1), 6'(g_ci0)};
    dlev         = 7'(g_dlev);
    model_step(din, vld, byp, aen, ld);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  // PRBS7 symbol through a two-tap channel: 50*a[n] + 12*a[n-1]
  function automatic int prbs_din();
    logic b;
    int   a, d;
    b    = lfsr[6] ^ lfsr[5];
    lfsr = {lfsr[5:0], b};
    a    = b ? 1 : -1;
    d    = 50*a + 12*a_prev;
    a_prev = a;
    return d;
  endfunction

  initial begin
    int c0, c1, n;
    rstb = 1'b0; bypass = 1'b0; adapt_en = 1'b0; load_coef = 1'b0;
    dlev = '0; coef_init = '0; dif.in_valid = 1'b0; dif.din = '0;
    g_dlev = 0; g_ci0 = 0; g_ci1 = 0;
    lfsr = 7'h7F; a_prev = -1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rstb = 1'b1;

    // bypass: sample passes straight through, taps untouched despite adapt_en
    g_dlev = 50;
    step("byp0", -5, 1, 1, 1, 0);
    chk("byp_eq", 32'(dif.eq_out), 32'(8'hFB));
    chk("byp_dout", 32'(dif.dout), 32'(0));
    chk("byp_vld", 32'(dif.out_valid), 32'(1));
    step("byp1", 0, 0, 1, 1, 0);
    chk("byp_vld_drop", 32'(dif.out_valid), 32'(0));
    chk("byp_coef", 32'(coef), 32'(0));
    step("byp2", -5, 1, 1, 1, 0);

    // fixed taps {20,0}, alternating +/-40 input
    g_ci0 = 20; g_ci1 = 0;
    step("ld20", 0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      step("alt", (i % 2) ? -40 : 40, 1, 0, 0, 0);
      if (i >= 2) begin
        chk("alt_eq", 32'(dif.eq_out), (i % 2) ? 32'(8'hC4) : 32'(8'h3C));
        chk("alt_dout", 32'(dif.dout), (i % 2) ? 32'(0) : 32'(1));
      end
    end

    // randomized traffic: gaps, bypass, loads, adapt toggles
    for (int i = 0; i < 400; i++) begin
      g_dlev = $urandom_range(0, 127);
      g_ci0  = int'($urandom_range(0, 63)) - 32;
      g_ci1  = int'($urandom_range(0, 63)) - 32;
      step("rnd", int'($urandom_range(0, 255)) - 128, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0));
    end

    // asynchronous reset in the middle of an accumulation window
    g_dlev = 50; g_ci0 = 0; g_ci1 = 0;
    step("pre_rst_ld", 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step("pre_rst", prbs_din(), 1, 0, 1, 0);
    chk("pre_rst_busy", 32'(adapt_busy), 32'(1));
    dif.in_valid = 1'b0;
    #2 rstb = 1'b0;
    model_reset();
    #1;
    check_outputs("midrst");
    @(posedge clk);
    #1 rstb = 1'b1;
    g_ci0 = 10; g_ci1 = 5;
    step("post_rst_ld", 0, 0, 0, 0, 1);
    step("post_rst", 0, 1, 0, 0, 0);
    chk("hist_neg", 32'(dif.eq_out), 32'(8'd15));

    // PRBS7 channel convergence from zero taps
    g_ci0 = 0; g_ci1 = 0; g_dlev = 50;
    step("conv_ld", 0, 0, 0, 0, 1);
    for (int i = 0; i < 40*(WIN+1) + 4; i++) step("conv", prbs_din(), 1, 0, 1, 0);
    c0 = int'($signed(coef[5:0]));
    c1 = int'($signed(coef[11:6]));
    chk("conv_c0", 32'(c0 >= 11 && c0 <= 13), 32'(1));
    chk("conv_c1", 32'(c1 >= -1 && c1 <= 1), 32'(1));

    // load_coef coincident with the tap update cycle
    n = 0;
    while (!m_upd_due && n < 3*WIN) begin
      step("to_upd", prbs_din(), 1, 0, 1, 0);
      n++;
    end
    chk("upd_reached", 32'(m_upd_due), 32'(1));
    g_ci0 = 7; g_ci1 = -3;
    step("ld_upd", prbs_din(), 1, 0, 1, 1);
    chk("ld_upd_coef", 32'(coef), 32'({6'(-3), 6'(7)}));
    chk("ld_upd_busy", 32'(adapt_busy), 32'(0));
    for (int i = 0; i < WIN + 8; i++) step("after_ld", prbs_din(), 1, 0, 1, 0);

    // forced positive error with coef[0] at the positive limit
    g_ci0 = 31; g_ci1 = 0;
    step("sat_ld", 0, 0, 0, 0, 1);
    g_dlev = 0;
    for (int i = 0; i < 2*(WIN+1) + 3; i++) step("sat", 100, 1, 0, 1, 0);
    chk("sat_c0", 32'(coef[5:0]), 32'(31));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
